// File: rtl/vdp_cpu_vram_port.sv
`default_nettype none
// ============================================================================
//  Module   : vdp_cpu_vram_port
//  Purpose  : CPU-side VRAM access front end. Decodes Z80 accesses to the
//             data port (#98) and control port (#99), assembles two-byte
//             address/register writes, drives toggle request handshakes to
//             the VRAM arbiter and keeps a one-byte read-ahead buffer.
//  Revision : 1.0  initial release
// ============================================================================
module vdp_cpu_vram_port (
  input  logic        CLK21M,
  input  logic        RESET,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_port,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_wait,
  input  logic [1:0]  DOTSTATE,
  input  logic [7:0]  PRAMDAT,
  input  logic        VDPVRAMWRACK,
  input  logic        VDPVRAMRDACK,
  input  logic        VDPVRAMADDRSETACK,
  input  logic        VDPVRAMREADINGR,
  output logic [7:0]  VDPVRAMACCESSDATA,
  output logic        VDPVRAMWRREQ,
  output logic        VDPVRAMRDREQ,
  output logic        VDPVRAMADDRSETREQ,
  output logic [16:0] VDPVRAMACCESSADDRTMP,
  output logic        VDPVRAMREADINGA,
  output logic        reg_wr_strobe,
  output logic [5:0]  reg_num,
  output logic [7:0]  reg_data,
  output logic [2:0]  reg_r14
);

  localparam logic [1:0] c_PORT_DATA = 2'd0;
  localparam logic [1:0] c_PORT_CTRL = 2'd1;
  localparam logic [1:0] c_DOT_READ  = 2'b01;
  localparam logic [5:0] c_REG_R14   = 6'd14;

  logic [7:0]  r_rd_buf;
  logic        r_readinga;
  logic [7:0]  r_access_data;
  logic        r_wrreq;
  logic        r_rdreq;
  logic        r_asreq;
  logic [16:0] r_addr_tmp;
  logic        r_reg_wr_strobe;
  logic [5:0]  r_reg_num;
  logic [7:0]  r_reg_data;
  logic [2:0]  r_reg_r14;
  logic        r_first_flag;
  logic [7:0]  r_first_byte;
  logic        r_hold_full;
  logic [7:0]  r_hold_data;

  logic w_wr_pend;
  logic w_as_pend;
  logic w_rd_pend;
  logic w_wait;
  logic w_accept;
  logic w_hold_issue;
  logic w_capture;

  // Handshake state: a request is outstanding while REQ and ACK differ.
  assign w_wr_pend    = r_wrreq ^ VDPVRAMWRACK;
  assign w_as_pend    = r_asreq ^ VDPVRAMADDRSETACK;
  assign w_rd_pend    = (r_rdreq ^ VDPVRAMRDACK) | (VDPVRAMREADINGR ^ r_readinga);
  assign w_wait       = r_hold_full | w_rd_pend | w_as_pend;
  // Requests arriving while busy are dropped outright.
  assign w_accept     = cpu_req & ~w_wait;
  // Held byte waits for both the previous write and any address set so it
  // never lands at a stale address.
  assign w_hold_issue = r_hold_full & ~w_wr_pend & ~w_as_pend;
  assign w_capture    = (DOTSTATE == c_DOT_READ) && (VDPVRAMREADINGR != r_readinga);

  // Capture arbiter-issued read data into the read-ahead buffer.
  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      r_rd_buf   <= 8'h00;
      r_readinga <= 1'b0;
    end else if (w_capture) begin
      r_rd_buf   <= PRAMDAT;
      r_readinga <= VDPVRAMREADINGR;
    end
  end

  // CPU port decode, two-byte assembly and request toggling.
  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      r_access_data   <= 8'h00;
      r_wrreq         <= 1'b0;
      r_rdreq         <= 1'b0;
      r_asreq         <= 1'b0;
      r_addr_tmp      <= 17'h00000;
      r_reg_wr_strobe <= 1'b0;
      r_reg_num       <= 6'h00;
      r_reg_data      <= 8'h00;
      r_reg_r14       <= 3'h0;
      r_first_flag    <= 1'b0;
      r_first_byte    <= 8'h00;
      r_hold_full     <= 1'b0;
      r_hold_data     <= 8'h00;
    end else begin
      r_reg_wr_strobe <= 1'b0;
      if (w_hold_issue) begin
        r_access_data <= r_hold_data;
        r_wrreq       <= ~r_wrreq;
        r_hold_full   <= 1'b0;
      end else if (w_accept) begin
        case (cpu_port)
          c_PORT_DATA: begin
            r_first_flag <= 1'b0;
            if (cpu_wr) begin
              if (!w_wr_pend && !w_as_pend) begin
                r_access_data <= cpu_din;
                r_wrreq       <= ~r_wrreq;
              end else begin
                r_hold_data <= cpu_din;
                r_hold_full <= 1'b1;
              end
            end else begin
              // The CPU has taken the buffered byte; prefetch the next one.
              r_rdreq <= ~r_rdreq;
            end
          end
          c_PORT_CTRL: begin
            if (!cpu_wr) begin
              r_first_flag <= 1'b0;
            end else if (!r_first_flag) begin
              r_first_byte <= cpu_din;
              r_first_flag <= 1'b1;
            end else begin
              r_first_flag <= 1'b0;
              if (cpu_din[7]) begin
                r_reg_num       <= cpu_din[5:0];
                r_reg_data      <= r_first_byte;
                r_reg_wr_strobe <= 1'b1;
                if (cpu_din[5:0] == c_REG_R14) begin
                  r_reg_r14 <= r_first_byte[2:0];
                end
              end else begin
                r_addr_tmp <= {r_reg_r14, cpu_din[5:0], r_first_byte};
                r_asreq    <= ~r_asreq;
                // bit 6 clear selects a read setup: prefetch immediately
                if (!cpu_din[6]) begin
                  r_rdreq <= ~r_rdreq;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cpu_dout             = r_rd_buf;
  assign cpu_wait             = w_wait;
  assign VDPVRAMACCESSDATA    = r_access_data;
  assign VDPVRAMWRREQ         = r_wrreq;
  assign VDPVRAMRDREQ         = r_rdreq;
  assign VDPVRAMADDRSETREQ    = r_asreq;
  assign VDPVRAMACCESSADDRTMP = r_addr_tmp;
  assign VDPVRAMREADINGA      = r_readinga;
  assign reg_wr_strobe        = r_reg_wr_strobe;
  assign reg_num              = r_reg_num;
  assign reg_data             = r_reg_data;
  assign reg_r14              = r_reg_r14;

endmodule
`default_nettype wire

// File: doc/vdp_cpu_vram_port.md
# vdp_cpu_vram_port

CPU-side VRAM access front end of the VDP. It decodes Z80 accesses to data port #98 and control port #99 and assembles two-byte address and register writes. It drives the toggle request handshakes (write, read, address-set) into the VRAM access arbiter, and captures arbiter-issued CPU read data into a one-byte read-ahead buffer. It sits directly upstream of the address bus arbiter and owns the VRAM address/data staging it consumes.

## Interface
Parameters: none.
- CLK21M  in  1  system clock
- RESET  in  1  asynchronous, active-high
- cpu_req  in  1  one-cycle access strobe
- cpu_wr  in  1  1 = write, 0 = read (qualified by cpu_req)
- cpu_port  in  2  0 = data #98, 1 = control #99, 2/3 ignored
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  read-ahead buffer contents
- cpu_wait  out  1  block busy; CPU must hold off cpu_req
- DOTSTATE  in  2  dot phase from timing generator
- PRAMDAT  in  8  byte-selected VRAM read data
- VDPVRAMWRACK, VDPVRAMRDACK, VDPVRAMADDRSETACK  in  1  arbiter ack toggles
- VDPVRAMREADINGR  in  1  arbiter read-issued toggle
- VDPVRAMACCESSDATA  out  8  CPU write byte
- VDPVRAMWRREQ, VDPVRAMRDREQ, VDPVRAMADDRSETREQ  out  1  request toggles
- VDPVRAMACCESSADDRTMP  out  17  new VRAM address
- VDPVRAMREADINGA  out  1  read-captured toggle
- reg_wr_strobe  out  1  one-cycle register write pulse
- reg_num  out  6  register number
- reg_data  out  8  register value
- reg_r14  out  3  VRAM address bits 16:14 (R14)

## Operation
- Reset: all outputs 0, first-byte flag 0, holding register empty.
- Handshakes: a request is pending while REQ != ACK. The block toggles REQ only. The arbiter toggles ACK.
- Pending terms:
  - wr_pend = WRREQ != WRACK
  - as_pend = ADDRSETREQ != ADDRSETACK
  - rd_pend = (RDREQ != RDACK) or (READINGR != READINGA)
- Port 0 write:
  - Clears the first-byte flag.
  - If neither wr_pend nor as_pend is set, VDPVRAMACCESSDATA <= cpu_din and WRREQ is toggled.
  - Otherwise the byte goes into a one-deep holding register (hold_full = 1).
  - Held byte issue rule: the held byte is issued the first cycle both wr_pend and as_pend are clear. That cycle loads VDPVRAMACCESSDATA, toggles WRREQ and clears hold_full.
  - A write must never be issued while as_pend is set, otherwise it lands at the stale address.
- Port 0 read:
  - Clears the first-byte flag.
  - The CPU samples cpu_dout in the cpu_req cycle.
  - The next cycle toggles RDREQ to prefetch the following byte.
- Read capture: when DOTSTATE == 2'b01 and READINGR != READINGA, the buffer <= PRAMDAT and READINGA <= READINGR.
- Port 1 write, flag = 0: latch cpu_din as the first byte and set the flag.
- Port 1 write, flag = 1: decode the second byte `s`, then clear the flag.
  - s[7] = 1 (register write):
    - reg_num <= s[5:0], reg_data <= first byte, reg_wr_strobe = 1 for one cycle.
    - If s[5:0] == 14, reg_r14 <= first[2:0] in the same cycle.
  - s[7] = 0 (address set):
    - VDPVRAMACCESSADDRTMP <= {reg_r14, s[5:0], first}.
    - Toggle ADDRSETREQ.
    - If s[6] = 0 (read setup), also toggle RDREQ in the same cycle.
- Port 1 read: clears the first-byte flag only; status data is returned elsewhere.
- Ports 2/3: ignored, no state change.
- cpu_wait = hold_full or rd_pend or as_pend.
- Protocol violation: a cpu_req while cpu_wait = 1 is dropped. The holding register is not overwritten and no toggle occurs.

## Timing
- Direct write: the WRREQ toggle and VDPVRAMACCESSDATA update are registered in the cycle after the cpu_req edge (latency 1).
- Address set: ADDRSETREQ (and RDREQ for a read setup) toggles 1 cycle after the second-byte cpu_req.
- reg_wr_strobe is high for exactly 1 cycle, 1 cycle after the second-byte cpu_req.
- Read capture: takes effect on the clock edge where DOTSTATE == 2'b01 is sampled together with the toggles unequal. cpu_dout is valid the following cycle.
- Simultaneous events:
  - Holding-register issue and a new cpu_req in the same cycle: the issue wins and cpu_wait blocks the request.
  - Read capture and a port 0 read in the same cycle cannot occur because rd_pend raises cpu_wait.
- Toggles are compared, never edge-detected, so an ack arriving in the same cycle as a request toggle is handled naturally.
- RESET mid-operation: all toggles return to 0 together with the arbiter's acks. Pending requests, the holding register and the first-byte flag are discarded.

## Test plan
- Address set for write: port 1 writes 0x34, then 0x52, with reg_r14 = 5 -> ADDRTMP = 0x15234, ADDRSETREQ toggles once, RDREQ unchanged, flag cleared.
- Write behind an address set: port 0 write 0xA5 while as_pend = 1 -> held, cpu_wait = 1. WRREQ toggles only after ADDRSETACK matches; VDPVRAMACCESSDATA = 0xA5.
- Read setup and prefetch: port 1 writes 0x00, then 0x10 -> ADDRSETREQ and RDREQ toggle. Arbiter model returns READINGR, PRAMDAT = 0x7E at DOTSTATE 01 -> cpu_dout = 0x7E, cpu_wait drops. A port 0 read then returns 0x7E and toggles RDREQ again.
- Register write: port 1 writes 0x03, then 0x8E -> reg_wr_strobe for one cycle, reg_num = 14, reg_data = 0x03, reg_r14 = 3.
- Flag reset: port 1 write 0x12, then port 1 read, then port 1 write 0x40 -> 0x40 is treated as a first byte; no ADDRSETREQ toggle.
- Reset mid-operation: assert RESET with hold_full = 1 and toggles unequal -> all outputs 0, cpu_wait = 0, no stray toggle after release.
